// File: rtl/ifetch.sv
// Instruction fetch stage: issues sequential reads to a one-cycle-latency
// instruction memory and presents fetched words to decode, with redirect and stall.
module ifetch #(
    parameter int unsigned WORD     = 32,
    parameter int unsigned ADDR     = 16,
    parameter int unsigned RESET_PC = 0
) (
    input  logic            clk,
    input  logic            rst,
    output logic [ADDR-1:0] imem_addr_o,
    output logic            imem_en_o,
    input  logic [WORD-1:0] imem_data_i,
    input  logic            br_taken_i,
    input  logic [ADDR-1:0] br_addr_i,
    input  logic            stall_i,
    output logic            v_o,
    output logic [WORD-1:0] inst_o,
    output logic [ADDR-1:0] origaddr_o
);

    logic [ADDR-1:0] pc_r;
    logic            req_v;
    logic [ADDR-1:0] req_addr;
    logic            v_r;
    logic [WORD-1:0] inst_r;
    logic [ADDR-1:0] addr_r;

    assign imem_addr_o = pc_r;
    // Read enable drops under stall so the memory holds the outstanding word.
    assign imem_en_o   = ~rst & ~stall_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_r     <= ADDR'(RESET_PC);
            req_v    <= 1'b0;
            req_addr <= '0;
            v_r      <= 1'b0;
            inst_r   <= '0;
            addr_r   <= '0;
        end else if (br_taken_i) begin
            // Redirect wins over stall; both in-flight slots are squashed.
            pc_r  <= br_addr_i;
            req_v <= 1'b0;
            v_r   <= 1'b0;
        end else if (!stall_i) begin
            req_v    <= 1'b1;
            req_addr <= pc_r;
            pc_r     <= pc_r + ADDR'(1);
            v_r      <= req_v;
            inst_r   <= imem_data_i;
            addr_r   <= req_addr;
        end
    end

    assign v_o        = v_r;
    assign inst_o     = inst_r;
    assign origaddr_o = addr_r;

endmodule

// File: doc/ifetch.md
IFETCH -- requirements
Module: ifetch

Interface
REQ-001 The module SHALL have parameter WORD, default 32, meaning instruction width in bits.
REQ-002 The module SHALL have parameter ADDR, default 16, meaning instruction address width in bits (word-addressed).
REQ-003 The module SHALL have parameter RESET_PC, default 0, meaning the first fetch address after reset.
REQ-004 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The module SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 The module SHALL have port imem_addr_o, output, ADDR bits: instruction memory read address.
REQ-007 The module SHALL have port imem_en_o, output, 1 bit: instruction memory read enable.
REQ-008 The module SHALL have port imem_data_i, input, WORD bits: memory read data, valid one cycle after an enabled read and held while imem_en_o=0.
REQ-009 The module SHALL have port br_taken_i, input, 1 bit: redirect request from execute.
REQ-010 The module SHALL have port br_addr_i, input, ADDR bits: redirect target.
REQ-011 The module SHALL have port stall_i, input, 1 bit: back-pressure from decode.
REQ-012 The module SHALL have port v_o, output, 1 bit: inst_o/origaddr_o hold a valid instruction.
REQ-013 The module SHALL have port inst_o, output, WORD bits: fetched instruction to decode.
REQ-014 The module SHALL have port origaddr_o, output, ADDR bits: address of inst_o.

Function
REQ-015 The module SHALL hold internal state: pc_r (next address to issue), req_v/req_addr (outstanding read, whose data is on imem_data_i), and registered outputs v_r/inst_r/addr_r driving v_o/inst_o/origaddr_o.
REQ-016 The module SHALL drive imem_addr_o = pc_r combinationally.
REQ-017 The module SHALL drive imem_en_o = ~rst & ~stall_i.
REQ-018 When br_taken_i=0 and stall_i=0, each edge SHALL: req_v<=1, req_addr<=pc_r, pc_r<=pc_r+1 (mod 2^ADDR), v_r<=req_v, inst_r<=imem_data_i, addr_r<=req_addr.
REQ-019 When br_taken_i=0 and stall_i=1, pc_r, req_v, req_addr, v_r, inst_r and addr_r SHALL all hold.
REQ-020 When br_taken_i=1, regardless of stall_i, the edge SHALL: pc_r<=br_addr_i, req_v<=0, v_r<=0; inst_r/addr_r are don't-care.
REQ-021 Redirect penalty SHALL be 2 cycles: the edge after the redirect edge issues br_addr_i, the next edge presents it with v_o=1 (absent stall).
REQ-022 Steady-state throughput SHALL be one instruction per cycle with no bubbles while stall_i=0 and no redirect.
REQ-023 No instruction SHALL be dropped or duplicated across any stall pattern; the instruction from a read outstanding at stall assertion SHALL be delivered in order once stall_i falls.
REQ-024 pc_r SHALL wrap from 2^ADDR-1 to 0 without error.
REQ-025 A stall released in the same cycle as a redirect SHALL follow REQ-020 only.

Reset
REQ-026 When rst=1 on an edge, the module SHALL set pc_r<=RESET_PC, req_v<=0, req_addr<=0, v_r<=0, inst_r<=0, addr_r<=0; reset SHALL override br_taken_i and stall_i.
REQ-027 During reset, outputs SHALL be v_o=0, inst_o=0, origaddr_o=0, imem_en_o=0, imem_addr_o=RESET_PC (after first reset edge).
REQ-028 After rst falls, the first read SHALL issue RESET_PC that cycle, and v_o=1 with origaddr_o=RESET_PC SHALL appear after the second rising edge.
REQ-029 Reset asserted mid-stream SHALL discard all outstanding and presented instructions within one edge.

Verification
REQ-030 Reset release, mem[i]=0x1000+i, stall_i=0 -> v_o rises on 2nd edge; origaddr_o sequence 0,1,2,3 with inst_o 0x1000..0x1003 on consecutive cycles.
REQ-031 Stall for 3 cycles while origaddr_o=5 -> origaddr_o/inst_o hold at 5 for 4 cycles, imem_en_o=0 throughout, then 6,7 follow with no gap or repeat.
REQ-032 br_taken_i=1, br_addr_i=0x40 while origaddr_o=8 -> v_o=0 for 2 cycles, then origaddr_o=0x40, 0x41 consecutively.
REQ-033 br_taken_i=1 with stall_i=1 held 2 further cycles -> v_o=0 throughout; after stall_i drops, 0x40 appears 2 edges later.
REQ-034 ADDR=4, RESET_PC=14 -> origaddr_o sequence 14,15,0,1.
REQ-035 rst=1 pulsed one cycle mid-stream at origaddr_o=20 -> v_o=0 next cycle; fetch restarts at RESET_PC per REQ-028.
